// File: rtl/msgmii_pkg.sv
// Shared M-SGMII definitions: buffer pointer/entry widths and the receive
// read-side FSM encoding.
package msgmii_pkg;

    localparam int unsigned MSGMII_PTRW = 4;
    localparam int unsigned MSGMII_ENTW = 10;

    typedef enum logic [0:0] {
        CNVRXO_SYNC = 1'b0,
        CNVRXO_RUN  = 1'b1
    } cnvrxo_state_e;

endpackage

// File: rtl/msgmii_cnvrxo_fltr_if.sv
// Receive elastic-buffer read port plus registered GMII receive outputs.
// The master modport is the read side; the slave is the buffer and MAC filter.
interface msgmii_cnvrxo_fltr_if;
    import msgmii_pkg::*;

    logic [MSGMII_PTRW-1:0] rxrdptr;
    logic [7:0]             rxdlcl1;
    logic                   rx_dvlcl1;
    logic                   rx_erlcl1;
    logic [7:0]             rxd;
    logic                   rx_dv;
    logic                   rx_er;

    modport master (
        output rxrdptr, rxd, rx_dv, rx_er,
        input  rxdlcl1, rx_dvlcl1, rx_erlcl1
    );

    modport slave (
        input  rxrdptr, rxd, rx_dv, rx_er,
        output rxdlcl1, rx_dvlcl1, rx_erlcl1
    );

endinterface

// File: rtl/msgmii_sync2.sv
// Generic two-flop bit synchroniser with asynchronous active-low reset.
module msgmii_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/msgmii_cnvrxo_fltr.sv
// M-SGMII receive elastic-buffer read side (rx_clki domain).
// Optional slip detection is compiled in by defining MSGMII_CNVRXO_SLIPDET_EN.
module msgmii_cnvrxo_fltr
    import msgmii_pkg::*;
(
    input  logic                    rx_clki,
    input  logic                    srrxi_n,
    input  logic                    rxhdptrpls,
    input  logic [MSGMII_PTRW-1:0]  rxhdptr,
    output logic                    locked,
    output logic [7:0]              slipcnt,
    msgmii_cnvrxo_fltr_if.master    bus
);

    cnvrxo_state_e          state_q, state_d;
    logic                   ps2, ps3, rise, slip;
    logic [MSGMII_PTRW-1:0] ptr_q, ptr_d;
    logic [MSGMII_ENTW-1:0] ent_q, ent_d;

    msgmii_sync2 u_sync (
        .clk   (rx_clki),
        .rst_n (srrxi_n),
        .d     (rxhdptrpls),
        .q     (ps2)
    );

    always_ff @(posedge rx_clki or negedge srrxi_n) begin
        if (!srrxi_n) ps3 <= 1'b0;
        else          ps3 <= ps2;
    end

    assign rise = ps2 & ~ps3;

    always_ff @(posedge rx_clki or negedge srrxi_n) begin
        if (!srrxi_n) state_q <= CNVRXO_SYNC;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CNVRXO_SYNC && rise) state_d = CNVRXO_RUN;
    end

    always_comb begin
        locked = (state_q == CNVRXO_RUN);
    end

    // rxhdptr is only looked at in the rise cycle, by which time it is stable.
    always_comb begin
        ptr_d = '0;
        ent_d = '0;
        unique case (state_q)
            CNVRXO_SYNC: ptr_d = rise ? rxhdptr : '0;
            CNVRXO_RUN: begin
                ptr_d = rise ? rxhdptr : ptr_q + 4'd1;
                ent_d = {bus.rx_erlcl1 | slip, bus.rx_dvlcl1, bus.rxdlcl1};
            end
        endcase
    end

    always_ff @(posedge rx_clki or negedge srrxi_n) begin
        if (!srrxi_n) begin
            ptr_q <= '0;
            ent_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            ent_q <= ent_d;
        end
    end

`ifdef MSGMII_CNVRXO_SLIPDET_EN
    logic [7:0] slipcnt_q;

    // A re-centre while a frame is being delivered corrupts that frame.
    assign slip = (state_q == CNVRXO_RUN) & rise & ent_q[8];

    always_ff @(posedge rx_clki or negedge srrxi_n) begin
        if (!srrxi_n)                         slipcnt_q <= 8'h00;
        else if (slip && slipcnt_q != 8'hFF)  slipcnt_q <= slipcnt_q + 8'd1;
    end

    assign slipcnt = slipcnt_q;
`else
    assign slip    = 1'b0;
    assign slipcnt = 8'h00;
`endif

    assign bus.rxrdptr = ptr_q;
    assign bus.rx_er   = ent_q[9];
    assign bus.rx_dv   = ent_q[8];
    assign bus.rxd     = ent_q[7:0];

endmodule

// File: tb/tb_msgmii_cnvrxo_fltr.sv
// Directed bench for msgmii_cnvrxo_fltr: table of per-cycle vectors plus
// hand sequences for slip, saturation and mid-frame reset.
module tb_msgmii_cnvrxo_fltr;

`ifdef MSGMII_CNVRXO_SLIPDET_EN
    localparam bit SlipEn = 1'b1;
`else
    localparam bit SlipEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pls;
    logic [3:0] hd;
    logic       locked;
    logic [7:0] slipcnt;
    logic [9:0] mem [16];

    int errors = 0;
    int checks = 0;

    msgmii_cnvrxo_fltr_if bus ();

    assign bus.rxdlcl1   = mem[bus.rxrdptr][7:0];
    assign bus.rx_dvlcl1 = mem[bus.rxrdptr][8];
    assign bus.rx_erlcl1 = mem[bus.rxrdptr][9];

    msgmii_cnvrxo_fltr dut (
        .rx_clki    (clk),
        .srrxi_n    (rst_n),
        .rxhdptrpls (pls),
        .rxhdptr    (hd),
        .locked     (locked),
        .slipcnt    (slipcnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pls;
        logic [3:0] hd;
        logic [3:0] ptr;
        logic       dv;
        logic       er;
        logic [7:0] d;
        logic       lock;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Low for two edges, then high for three: the reload lands on the fifth edge.
    task automatic pulse_reload(input logic [3:0] h);
        pls = 1'b0;
        step();
        step();
        pls = 1'b1;
        hd  = h;
        step();
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 10'h000;
        for (int i = 10; i < 16; i++) mem[i] = {2'b01, 8'h55};
        mem[0] = {2'b01, 8'h55};
        mem[1] = {2'b01, 8'hD5};
        mem[5] = {2'b10, 8'h5A};

        //            pls   hd     ptr    dv    er    d      lock
        tbl[0]  = '{1'b1, 4'hA, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 4'hA, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 4'hA, 4'hA, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 4'hA, 4'hB, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[4]  = '{1'b1, 4'hA, 4'hC, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[5]  = '{1'b1, 4'hA, 4'hD, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[6]  = '{1'b1, 4'hA, 4'hE, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[7]  = '{1'b1, 4'hA, 4'hF, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[8]  = '{1'b1, 4'hA, 4'h0, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[9]  = '{1'b1, 4'hA, 4'h1, 1'b1, 1'b0, 8'h55, 1'b1};
        tbl[10] = '{1'b1, 4'hA, 4'h2, 1'b1, 1'b0, 8'hD5, 1'b1};
        tbl[11] = '{1'b1, 4'hA, 4'h3, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{1'b0, 4'h3, 4'h4, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[13] = '{1'b0, 4'h3, 4'h5, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[14] = '{1'b1, 4'h3, 4'h6, 1'b0, 1'b1, 8'h5A, 1'b1};
        tbl[15] = '{1'b1, 4'h3, 4'h7, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[16] = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[17] = '{1'b0, 4'h4, 4'h4, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[18] = '{1'b0, 4'h4, 4'h5, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[19] = '{1'b1, 4'h4, 4'h6, 1'b0, 1'b1, 8'h5A, 1'b1};
        tbl[20] = '{1'b1, 4'h4, 4'h7, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[21] = '{1'b1, 4'h4, 4'h4, 1'b0, 1'b0, 8'h00, 1'b1};

        rst_n = 1'b0;
        pls   = 1'b0;
        hd    = 4'h0;
        @(negedge clk);
        chk("rst_ptr", 32'(bus.rxrdptr), 32'h0);
        chk("rst_rxd", 32'(bus.rxd), 32'h00);
        chk("rst_dv", 32'(bus.rx_dv), 32'h0);
        chk("rst_er", 32'(bus.rx_er), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_slipcnt", 32'(slipcnt), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_ptr", 32'(bus.rxrdptr), 32'h0);
            chk("idle_dv", 32'(bus.rx_dv), 32'h0);
            chk("idle_locked", 32'(locked), 32'h0);
        end

        for (int i = 0; i < 22; i++) begin
            pls = tbl[i].pls;
            hd  = tbl[i].hd;
            step();
            chk($sformatf("v%0d_ptr", i), 32'(bus.rxrdptr), 32'(tbl[i].ptr));
            chk($sformatf("v%0d_dv", i), 32'(bus.rx_dv), 32'(tbl[i].dv));
            chk($sformatf("v%0d_er", i), 32'(bus.rx_er), 32'(tbl[i].er));
            chk($sformatf("v%0d_rxd", i), 32'(bus.rxd), 32'(tbl[i].d));
            chk($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lock));
        end

        // Reload while a frame is on the outputs.
        mem[7] = {2'b01, 8'h77};
        mem[8] = {2'b01, 8'h77};
        pulse_reload(4'hA);
        chk("slip_ptr", 32'(bus.rxrdptr), 32'hA);
        chk("slip_dv", 32'(bus.rx_dv), 32'h1);
        chk("slip_rxd", 32'(bus.rxd), 32'h77);
        chk("slip_er", 32'(bus.rx_er), SlipEn ? 32'h1 : 32'h0);
        chk("slip_cnt1", 32'(slipcnt), SlipEn ? 32'h1 : 32'h0);
        step();
        chk("slip_next_ptr", 32'(bus.rxrdptr), 32'hB);
        chk("slip_next_er", 32'(bus.rx_er), 32'h0);
        chk("slip_next_rxd", 32'(bus.rxd), 32'h55);

        for (int i = 0; i < 16; i++) mem[i] = {2'b01, 8'h11};
        for (int i = 0; i < 299; i++) pulse_reload(4'h2);
        chk("sat_ptr", 32'(bus.rxrdptr), 32'h2);
        chk("sat_cnt", 32'(slipcnt), SlipEn ? 32'hFF : 32'h00);
        chk("sat_er", 32'(bus.rx_er), SlipEn ? 32'h1 : 32'h0);
        step();
        chk("sat_hold_cnt", 32'(slipcnt), SlipEn ? 32'hFF : 32'h00);
        chk("sat_free_run", 32'(bus.rxrdptr), 32'h3);

        // Mid-frame asynchronous reset.
        chk("pre_rst_dv", 32'(bus.rx_dv), 32'h1);
        rst_n = 1'b0;
        pls   = 1'b0;
        #1;
        chk("arst_ptr", 32'(bus.rxrdptr), 32'h0);
        chk("arst_dv", 32'(bus.rx_dv), 32'h0);
        chk("arst_rxd", 32'(bus.rxd), 32'h00);
        chk("arst_locked", 32'(locked), 32'h0);
        chk("arst_slipcnt", 32'(slipcnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_ptr", 32'(bus.rxrdptr), 32'h0);
            chk("post_rst_locked", 32'(locked), 32'h0);
            chk("post_rst_dv", 32'(bus.rx_dv), 32'h0);
        end
        pulse_reload(4'h5);
        chk("relock_ptr", 32'(bus.rxrdptr), 32'h5);
        chk("relock_locked", 32'(locked), 32'h1);
        chk("relock_dv", 32'(bus.rx_dv), 32'h0);
        chk("relock_slipcnt", 32'(slipcnt), 32'h0);
        step();
        chk("relock_step_ptr", 32'(bus.rxrdptr), 32'h6);
        chk("relock_step_dv", 32'(bus.rx_dv), 32'h1);
        chk("relock_step_rxd", 32'(bus.rxd), 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
